// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - display driver control and output bundle
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output enable, load, digits_in, dp_in,
        input  seg, an, frame_done
    );

    modport slave (
        input  enable, load, digits_in, dp_in,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multiplexed seven-segment scanner with double-buffered digits
module seg_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter bit HEX_MODE      = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [7:0]       ERR_GLYPH = 8'b11011011;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] disp_dig_q, disp_dig_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    wrap_q, wrap_d;
    logic                    frame_done_q, frame_done_d;

    logic       tick;
    logic       boundary;
    logic [3:0] code;
    logic       dp;
    logic       blank;
    logic       higher_zero;
    logic [7:0] gl;

    function automatic logic [7:0] glyph(input logic [3:0] c);
        case (c)
            4'h0:    glyph = 8'b00000011;
            4'h1:    glyph = 8'b10011111;
            4'h2:    glyph = 8'b00100101;
            4'h3:    glyph = 8'b00001101;
            4'h4:    glyph = 8'b10011001;
            4'h5:    glyph = 8'b01001001;
            4'h6:    glyph = 8'b01000001;
            4'h7:    glyph = 8'b00011111;
            4'h8:    glyph = 8'b00000001;
            4'h9:    glyph = 8'b00001001;
            4'hA:    glyph = HEX_MODE ? 8'b00010001 : ERR_GLYPH;
            4'hB:    glyph = HEX_MODE ? 8'b11000001 : ERR_GLYPH;
            4'hC:    glyph = HEX_MODE ? 8'b01100011 : ERR_GLYPH;
            4'hD:    glyph = HEX_MODE ? 8'b10000101 : ERR_GLYPH;
            4'hE:    glyph = HEX_MODE ? 8'b01100001 : ERR_GLYPH;
            default: glyph = HEX_MODE ? 8'b01110001 : ERR_GLYPH;
        endcase
    endfunction

    // Scan sequencing and the shadow-to-display commit at the frame wrap
    always_comb begin
        tick         = bus.enable && (cnt_q == CNT_LAST);
        boundary     = tick && (idx_q == IDX_LAST);
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        if (!bus.enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (tick) begin
            cnt_d = '0;
            idx_d = boundary ? '0 : idx_q + IDX_W'(1);
        end

        disp_dig_d   = disp_dig_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;
        if (boundary && pending_q) begin
            disp_dig_d = shadow_dig_q;
            disp_dp_d  = shadow_dp_q;
            pending_d  = 1'b0;
        end
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        if (bus.load) begin
            shadow_dig_d = bus.digits_in;
            shadow_dp_d  = bus.dp_in;
            pending_d    = 1'b1;
        end

        wrap_d       = boundary;
        frame_done_d = wrap_q && bus.enable;
    end

    // Outputs follow the current digit; frame_done lines up with the first new digit 0
    always_comb begin
        code        = 4'h0;
        dp          = 1'b0;
        blank       = 1'b0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero && (disp_dig_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                code  = disp_dig_q[4*i +: 4];
                dp    = disp_dp_q[i];
                blank = BLANK_LEADING && higher_zero && (i != 0);
            end
        end
        gl = glyph(code);
        if (blank) begin
            gl = 8'hFF;
        end
        if (bus.enable) begin
            seg_d = {gl[7:1], ~dp};
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
        end else begin
            seg_d = 8'hFF;
            an_d  = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            disp_dig_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= 8'hFF;
            an_q         <= '1;
            wrap_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            disp_dig_q   <= disp_dig_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            wrap_q       <= wrap_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised, time-multiplexed multi-digit seven-segment display driver for the board's common-anode displays. It captures a packed vector of 4-bit codes and per-digit decimal points. It then scans the digits one at a time at a programmable refresh rate, using the team's 8-bit active-low segment encoding. Over a single-digit decoder it adds hex glyphs, leading-zero blanking, tear-free double-buffered updates and a frame strobe.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8); digit 0 is least significant.
- REFRESH_DIV, 50000, clocks each digit is lit (>= 2).
- HEX_MODE, 1, 1: codes 10..15 show A,b,C,d,E,F; 0: codes 10..15 show error glyph 8'b11011011.
- BLANK_LEADING, 1, 1: suppress leading zeros; 0: show all digits.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- enable  input  1  1: scan; 0: display dark, scan held at digit 0.
- load  input  1  one-cycle strobe; captures digits_in/dp_in into shadow register.
- digits_in  input  4*NUM_DIGITS  code for digit i in bits [4i+3:4i].
- dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
- seg  output  8  {a,b,c,d,e,f,g,dp}, active-low, registered.
- an  output  NUM_DIGITS  digit select, active-low, one-hot-low when enabled, registered.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

## Operation
- Glyphs: 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001. With HEX_MODE=1: A=00010001, b=11000001, C=01100011, d=10000101, E=01100001, F=01110001. These values have dp off. When dp_in[i] is set, seg[0] is 0.
- Blank glyph is 8'b11111111. When BLANK_LEADING=1, digit i is blank if it and every higher digit hold code 0. Digit 0 is never blanked. A blanked digit still honours its dp bit.
- State:
  - prescaler cnt, range 0..REFRESH_DIV-1.
  - digit index idx, range 0..NUM_DIGITS-1.
  - shadow register plus pending flag.
  - display register.
- load: shadow <= {digits_in, dp_in}, pending <= 1.
- tick = enable && cnt==REFRESH_DIV-1. On tick, cnt <= 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0, and that wrap is the frame boundary.
- At the frame boundary, if pending, display <= shadow and pending <= 0. load in the same cycle has priority: the shadow value held before the edge is committed, the new value goes into shadow, and pending stays 1.
- Display data changes only at frame boundaries, so a frame never mixes old and new digits.
- enable=0: cnt <= 0, idx <= 0, seg <= 8'hFF, an <= all ones. Shadow, pending and display are retained, and load still works.
- NUM_DIGITS=1: idx is constant 0, and every tick is a frame boundary.

## Timing
- Reset (rst_n low at clk edge): cnt=0, idx=0, shadow=0, display=0, pending=0, seg=8'hFF, an=all ones, frame_done=0. Reset mid-frame takes effect at that edge; the next scan starts at digit 0 with a full slot.
- Outputs are registered from the current idx and display state. The cycle after enable rises, an[0]=0 and seg shows digit 0.
- Each digit is driven for exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- frame_done is high for the one cycle after the frame-boundary edge, aligned with the newly committed display data appearing on digit 0.
- Load-to-visible latency is at most one frame plus one cycle.
- No more than one an bit is low in any cycle, and there is no overlap between consecutive digit slots.

## Test plan
- **Reset and first frame.** NUM_DIGITS=4, REFRESH_DIV=4. Reset, then enable=1 with no load → an sequence 1110,1101,1011,0111, 4 cycles each. seg=00000011 on digit 0 and 8'hFF on digits 1..3 (leading blank). frame_done pulses every 16 cycles.
- **Double-buffered update.** load digits_in=16'h1234, dp_in=4'b0100 mid-frame → the current frame is unchanged. From the next frame, digit 0=10011001, digit 1=00001101, digit 2=00100100 (dp on), digit 3=10011111.
- **Hex mode.** Load 16'hABEF with HEX_MODE=1 → digits 0..3 show 01110001, 01100001, 11000001, 00010001. Rerun with HEX_MODE=0 → all four show 11011011.
- **Blanking.** Load 16'h0500 → digit 3 is 8'hFF. Digits 2, 1 and 0 show 01001001, 00000011 and 00000011. Rerun with BLANK_LEADING=0 → digit 3=00000011.
- **Simultaneous load and wrap.** Assert load=16'h1111 one frame, then load=16'h2222 exactly on a frame-boundary cycle → 1111 is displayed for one frame, then 2222.
- **Disable and reset mid-scan.** Drop enable mid-slot → next cycle seg=8'hFF and an=all ones. Re-enable → scan restarts at digit 0 with a full slot and the retained data. Pulse rst_n low mid-frame → all reset values hold on the next edge.
